// File: rtl/camera_pkg.sv
// Shared types and constants for the DVP frame capture block: FSM states,
// frame-size helper and the byte lane order of a packed RAM word.
`timescale 1ns/1ps
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  localparam int unsigned H_BYTES_DEFAULT = 640;
  localparam int unsigned V_LINES_DEFAULT = 240;

  // Byte lanes of a RAM word: first byte of a pixel sits in the high half of its 16-bit slot.
  localparam int unsigned LANE_B0 = 1;
  localparam int unsigned LANE_B1 = 0;
  localparam int unsigned LANE_B2 = 3;
  localparam int unsigned LANE_B3 = 2;

  function automatic int unsigned frame_words(input int unsigned h_bytes,
                                              input int unsigned v_lines);
    return (h_bytes * v_lines) / 4;
  endfunction

  localparam int unsigned FRAME_WORDS = frame_words(H_BYTES_DEFAULT, V_LINES_DEFAULT);

  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] w;
    w = '0;
    w[8*LANE_B0 +: 8] = b0;
    w[8*LANE_B1 +: 8] = b1;
    w[8*LANE_B2 +: 8] = b2;
    w[8*LANE_B3 +: 8] = b3;
    return w;
  endfunction

endpackage

// File: rtl/camera_dvp_capture_if.sv
// DVP pixel bus, bridge request handshake and frame-RAM write port of camera_dvp_capture.
// master = camera/bridge/RAM side, slave = the capture block.
`timescale 1ns/1ps
interface camera_dvp_capture_if #(
  parameter int unsigned ADDR_W = 16
);

  logic              CAM_PCLK;
  logic              CAM_VSYNC;
  logic              CAM_HREF;
  logic [7:0]        CAM_DATA;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_WADDR;
  logic [31:0]       RAM_WDATA;
  logic              FRAME_ERR;

  modport master (
    output CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA, DATA_VALID,
    input  DATA_READY, RAM_WE, RAM_WADDR, RAM_WDATA, FRAME_ERR
  );

  modport slave (
    input  CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA, DATA_VALID,
    output DATA_READY, RAM_WE, RAM_WADDR, RAM_WDATA, FRAME_ERR
  );

endinterface

// File: rtl/cam_sync.sv
// Two-flop synchroniser for a W-bit bundle plus one history flop on the
// EDGE_W most significant bits, so callers can detect edges on them.
`timescale 1ns/1ps
module cam_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned EDGE_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      d,
  output logic [W-1:0]      sync,
  output logic [EDGE_W-1:0] hist
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      hist <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
      meta <= d;
      sync <= meta;
      hist <= sync[W-1 -: EDGE_W];
    end
  end

endmodule

// File: rtl/camera_dvp_capture.sv
// Captures one DVP frame into the frame RAM on request from the bridge.
// Optional macro CAM_SIZE_CHECK_EN builds the early-end/overflow FRAME_ERR logic.
`timescale 1ns/1ps
module camera_dvp_capture
  import camera_pkg::*;
#(
  parameter int unsigned H_BYTES = H_BYTES_DEFAULT,
  parameter int unsigned V_LINES = V_LINES_DEFAULT,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  camera_dvp_capture_if.slave bus
);

  localparam int unsigned     WORDS     = frame_words(H_BYTES, V_LINES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  // Pixel bus: {PCLK, VSYNC, HREF, DATA}, edge history on PCLK and VSYNC.
  logic [10:0] sync_bus;
  logic [1:0]  edge_hist;

  cam_sync #(.W(11), .EDGE_W(2)) u_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .d     ({bus.CAM_PCLK, bus.CAM_VSYNC, bus.CAM_HREF, bus.CAM_DATA}),
    .sync  (sync_bus),
    .hist  (edge_hist)
  );

  logic       pclk_rise, vsync_fall, vsync_rise, byte_strobe;
  logic       vsync_s, href_s;
  logic [7:0] data_s;

  assign vsync_s     = sync_bus[9];
  assign href_s      = sync_bus[8];
  assign data_s      = sync_bus[7:0];
  assign pclk_rise   = sync_bus[10] & ~edge_hist[1];
  assign vsync_fall  = ~vsync_s & edge_hist[0];
  assign vsync_rise  = vsync_s & ~edge_hist[0];
  assign byte_strobe = pclk_rise & href_s;

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic              last_written, word_done;

  assign last_written = ram_we && (ram_waddr == LAST_ADDR);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no branch leaves state_next unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (bus.DATA_VALID) state_next = ARM;
      GUARD:   state_next = IDLE;
      ARM:     if (!bus.DATA_VALID) state_next = IDLE;
               else if (vsync_fall)  state_next = CAPTURE;
      CAPTURE: if (!bus.DATA_VALID) state_next = IDLE;
               else if (vsync_rise || last_written) state_next = DONE;
      DONE:    state_next = GUARD;
      default: state_next = IDLE;
    endcase
  end

  // A word is only committed while the capture continues; partial words on exit are dropped.
  assign word_done = (state == CAPTURE) && (state_next == CAPTURE) &&
                     byte_strobe && (byte_cnt == 2'd3);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      byte_cnt  <= '0;
      shift     <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= word_done;
      if (word_done)
        ram_wdata <= pack_word(shift[23:16], shift[15:8], shift[7:0], data_s);

      if (state != CAPTURE || state_next != CAPTURE) begin
        byte_cnt <= '0;
      end else if (byte_strobe) begin
        shift    <= {shift[15:0], data_s};
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Address holds during the strobe, advances after it and saturates at the last word.
      if (state != CAPTURE)
        ram_waddr <= '0;
      else if (ram_we && ram_waddr != LAST_ADDR)
        ram_waddr <= ram_waddr + 1'b1;
    end
  end

  assign bus.DATA_READY = (state == DONE);
  assign bus.RAM_WE     = ram_we;
  assign bus.RAM_WADDR  = ram_waddr;
  assign bus.RAM_WDATA  = ram_wdata;

`ifdef CAM_SIZE_CHECK_EN
  logic frame_err, tail_watch;

  // After a complete frame, keep watching until VSYNC rises: any further byte is an overflow.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frame_err  <= 1'b0;
      tail_watch <= 1'b0;
    end else if (state == IDLE && state_next == ARM) begin
      frame_err  <= 1'b0;
      tail_watch <= 1'b0;
    end else begin
      if (state == CAPTURE && state_next == DONE && !last_written)
        frame_err <= 1'b1;
      if (tail_watch && byte_strobe)
        frame_err <= 1'b1;

      if (state == CAPTURE && state_next == DONE && last_written && !vsync_s)
        tail_watch <= 1'b1;
      else if (vsync_s)
        tail_watch <= 1'b0;
    end
  end

  assign bus.FRAME_ERR = frame_err;
`else
  assign bus.FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_camera_dvp_capture.sv
// Self-checking bench for camera_dvp_capture on a reduced 8x2-byte frame;
// expected RAM writes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_camera_dvp_capture;

`ifdef CAM_SIZE_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic HCLK;
  logic HRESETn;

  camera_dvp_capture_if #(.ADDR_W(16)) bus ();

  camera_dvp_capture #(
    .H_BYTES (8),
    .V_LINES (2),
    .ADDR_W  (16)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt      = 0;
  int ready_cnt   = 0;
  logic [47:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // RAM-side monitor and bridge model: compare writes, count DATA_READY, drop the request after it.
  initial begin
    logic [47:0] exp;
    forever begin
      @(negedge HCLK);
      if (bus.RAM_WE === 1'b1) begin
        wr_cnt++;
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check("ram_write", 64'({bus.RAM_WADDR, bus.RAM_WDATA}), 64'(exp));
        end
      end
      if (bus.DATA_READY === 1'b1) begin
        ready_cnt++;
        bus.DATA_VALID = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pclk_idle(input int n);
    bus.CAM_HREF = 1'b0;
    repeat (n) begin
      #40 bus.CAM_PCLK = 1'b1;
      #40 bus.CAM_PCLK = 1'b0;
    end
  endtask

  task automatic cam_byte(input logic [7:0] d);
    bus.CAM_DATA = d;
    bus.CAM_HREF = 1'b1;
    #40 bus.CAM_PCLK = 1'b1;
    #40 bus.CAM_PCLK = 1'b0;
  endtask

  task automatic frame_start();
    bus.CAM_VSYNC = 1'b0;
    pclk_idle(3);
  endtask

  task automatic frame_end();
    pclk_idle(2);
    bus.CAM_VSYNC = 1'b1;
    pclk_idle(3);
  endtask

  // Bytes base+first .. base+first+count-1, lines of 8 bytes; expected words for the 4-word frame.
  task automatic send_bytes(input int base, input int first, input int count, input bit expect_wr);
    logic [7:0] b0, b1, b2, b3;
    for (int i = first; i < first + count; i++) begin
      if (i % 8 == 0 && i != first) pclk_idle(2);
      if (expect_wr && (i % 4 == 3) && (i / 4 < 4)) begin
        b0 = 8'(base + i - 3);
        b1 = 8'(base + i - 2);
        b2 = 8'(base + i - 1);
        b3 = 8'(base + i);
        sb.push_back({16'(i / 4), b2, b3, b0, b1});
      end
      cam_byte(8'(base + i));
    end
  endtask

  task automatic end_test(input string tag, input int exp_wr, input int exp_ready, input bit exp_err);
    #200;
    check({tag, "_writes"}, 64'(wr_cnt), 64'(exp_wr));
    check({tag, "_ready"}, 64'(ready_cnt), 64'(exp_ready));
    check({tag, "_frame_err"}, 64'(bus.FRAME_ERR), 64'(exp_err));
    check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    sb.delete();
    wr_cnt    = 0;
    ready_cnt = 0;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.RAM_WE, bus.DATA_READY, bus.FRAME_ERR, bus.RAM_WADDR, bus.RAM_WDATA});
  endfunction

  initial begin
    HRESETn        = 1'b0;
    bus.CAM_PCLK   = 1'b0;
    bus.CAM_VSYNC  = 1'b1;
    bus.CAM_HREF   = 1'b0;
    bus.CAM_DATA   = 8'h00;
    bus.DATA_VALID = 1'b0;
    #23 HRESETn = 1'b1;
    #50;
    check("reset_outputs", out_vec(), 64'd0);

    // Basic frame: bytes 0x01..0x10, request before VSYNC fall.
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h01, 0, 16, 1'b1);
    frame_end();
    end_test("basic", 4, 1, 1'b0);
    check("basic_addr_cleared", 64'(bus.RAM_WADDR), 64'd0);

    // Request raised mid-frame: nothing until the next VSYNC fall, then a full frame.
    frame_start();
    send_bytes(8'h11, 0, 6, 1'b0);
    bus.DATA_VALID = 1'b1;
    send_bytes(8'h11, 6, 10, 1'b0);
    frame_end();
    frame_start();
    send_bytes(8'h21, 0, 16, 1'b1);
    frame_end();
    end_test("midframe", 4, 1, 1'b0);

    // Early end after 5 bytes: one word, partial word dropped.
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h41, 0, 5, 1'b1);
    frame_end();
    end_test("early_end", 1, 1, ERR_EN);

    // Overflow: 20 bytes into a 16-byte frame.
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h51, 0, 20, 1'b1);
    frame_end();
    end_test("overflow", 4, 1, ERR_EN);

    // Abort after two words, then a fresh request restarts at address 0.
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h61, 0, 8, 1'b1);
    bus.DATA_VALID = 1'b0;
    #80;
    check("abort_addr", 64'(bus.RAM_WADDR), 64'd0);
    send_bytes(8'h61, 8, 8, 1'b0);
    frame_end();
    end_test("abort", 2, 0, 1'b0);
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h71, 0, 16, 1'b1);
    frame_end();
    end_test("after_abort", 4, 1, 1'b0);

    // Asynchronous reset mid-capture, then a clean frame.
    bus.DATA_VALID = 1'b1;
    frame_start();
    send_bytes(8'h81, 0, 6, 1'b1);
    HRESETn = 1'b0;
    #1;
    check("reset_midframe", out_vec(), 64'd0);
    #39 HRESETn = 1'b1;
    #40;
    send_bytes(8'h81, 6, 10, 1'b0);
    frame_end();
    frame_start();
    send_bytes(8'h91, 0, 16, 1'b1);
    frame_end();
    end_test("after_reset", 5, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
